program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- 16-bit program counter for the Hack-style CPU datapath.
- Built on the same load-gated storage as the single-bit register, and sits directly downstream of it.
- Each cycle selects the next instruction address: clear, jump (load), increment, or hold.
- Output drives the instruction memory address and feeds back into its own incrementer.

Parameters:
- WIDTH, 16, counter and address width in bits.
- RESET_VAL, 0, value taken on rst_n low and on clr.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  functional synchronous clear; this is the CPU "reset" pin.
- load  input  1  jump: take in on the next edge.
- inc  input  1  advance by one on the next edge.
- in  input  WIDTH  jump target.
- out  output  WIDTH  current PC, registered.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. Every state change happens on the rising edge of clk.
- Priority on each edge, highest first:
  - rst_n == 0 → out <= RESET_VAL.
  - else clr → out <= RESET_VAL.
  - else load → out <= in.
  - else inc → out <= out + 1, modulo 2^WIDTH.
  - else out holds.
- Reset value of out is RESET_VAL (0).
- Latency: a control or data change at edge N is visible on out after edge N, i.e. in cycle N+1. There is no combinational path from any input to out.
- Simultaneous events follow the priority above:
  - load and inc together → load wins; no +1 is applied to in.
  - clr with load → RESET_VAL.
- Wrap: out == 2^WIDTH-1 with inc → out becomes 0. No saturation and no error.
- rst_n low mid-sequence → out is RESET_VAL after that edge. Counting resumes from RESET_VAL on the first edge with rst_n high.
- in is sampled only on an edge where load wins; it is ignored otherwise.
- The incrementer is WIDTH bits wide and the carry-out is discarded, unless the optional feature is compiled in.
- State: the internal state is the out register only. The effective operating modes are RESET, CLEAR, JUMP, COUNT and HOLD, decoded each cycle from the priority chain.

Optional Feature:
- Macro: PROGRAM_COUNTER_WRAP_FLAG_EN.
- When defined:
  - An extra output port wrap (1 bit, registered) is added.
  - wrap is 1 for exactly the cycle after an edge on which COUNT took out from 2^WIDTH-1 to 0. It is 0 at all other times.
  - wrap resets to 0 on rst_n low or on clr.
  - A load of 0 never sets wrap.
- When undefined: the port is absent and wrap-around is silent.

Decomposition:
- Shared package holds:
  - PC_WIDTH = 16.
  - PC_RESET_VAL = 0.
  - A mode enum {PC_RESET, PC_CLEAR, PC_JUMP, PC_COUNT, PC_HOLD}, also used by bench coverage.
- One sub-module is natural: pc_register, a WIDTH-bit load-gated register with synchronous active-low reset.
- The top level holds the priority mux and the incrementer, and drives pc_register with load = 1 whenever the mode is not HOLD.

Test Plan:
- Reset and count: hold rst_n=0 for 2 cycles → out=0x0000. Release with inc=1 for 5 cycles → out steps 1,2,3,4,5.
- Jump: load=1, in=0x1234 for 1 cycle, then inc=1 for 2 cycles → out=0x1234, then 0x1235, then 0x1236.
- Priority: load=1, inc=1, in=0x00A0 → out=0x00A0. Next cycle clr=1, load=1, in=0x0055 → out=0x0000.
- Wrap: load 0xFFFE, then inc for 2 cycles → out=0xFFFF, then 0x0000. With PROGRAM_COUNTER_WRAP_FLAG_EN, wrap=1 only in the cycle out reads 0x0000.
- Hold and mid-run reset: out=0x0010 with all controls 0 for 3 cycles → out stays 0x0010. Then rst_n=0 with inc=1 and load=1 → out=0x0000. Release → counting resumes at 0x0001.

Source files
------------

// File: rtl/program_counter_pkg.sv
// ---------------------------------------------------------------------------
// program_counter_pkg
// Shared definitions for the Hack-style program counter slice.
//   PC_WIDTH     : default counter / instruction-address width
//   PC_RESET_VAL : default value taken on reset and on clear
//   pc_mode_e    : per-cycle operating mode decoded from the control
//                  priority chain; also used by the bench for coverage
// Optional feature macro used elsewhere: PROGRAM_COUNTER_WRAP_FLAG_EN
// ---------------------------------------------------------------------------
package program_counter_pkg;

  localparam int PC_WIDTH     = 16;
  localparam int PC_RESET_VAL = 0;

  typedef enum logic [2:0] {
    PC_RESET = 3'd0,
    PC_CLEAR = 3'd1,
    PC_JUMP  = 3'd2,
    PC_COUNT = 3'd3,
    PC_HOLD  = 3'd4
  } pc_mode_e;

endpackage : program_counter_pkg

// File: rtl/program_counter_register.sv
// ---------------------------------------------------------------------------
// pc_register
// WIDTH-bit load-gated storage register with synchronous active-low reset.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, q <= RESET_VAL
//   i_load : when 1, capture i_d on the next edge; otherwise hold
//   i_d    : data to capture
//   o_q    : registered contents
// ---------------------------------------------------------------------------
module pc_register
  import program_counter_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pc_register

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// 16-bit (by default) program counter for the Hack-style CPU datapath.
// Every edge selects, highest priority first: reset, clear, jump (load),
// increment, hold. The output is purely registered; no input reaches out
// combinationally.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, out <= RESET_VAL
//   clr   : functional synchronous clear (CPU reset pin), out <= RESET_VAL
//   load  : jump, out <= in on the next edge
//   inc   : advance, out <= out + 1 (mod 2^WIDTH) on the next edge
//   in    : jump target, sampled only when load wins
//   out   : current PC
//   wrap  : (only with PROGRAM_COUNTER_WRAP_FLAG_EN) registered flag, high
//           for the single cycle after a count step from all-ones to zero
// Optional feature macro: PROGRAM_COUNTER_WRAP_FLAG_EN
// ---------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  output logic [WIDTH-1:0] out,
  output logic             wrap
`else
  output logic [WIDTH-1:0] out
`endif
);

  pc_mode_e         w_mode;
  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_next;
  logic             w_reg_load;

  // Mode decode: the whole priority chain collapses to one enum so the
  // next-value mux and the wrap flag agree on which action won.
  always_comb begin
    w_mode = PC_HOLD;
    if (!rst_n) begin
      w_mode = PC_RESET;
    end else if (clr) begin
      w_mode = PC_CLEAR;
    end else if (load) begin
      w_mode = PC_JUMP;
    end else if (inc) begin
      w_mode = PC_COUNT;
    end
  end

`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  // Incrementer keeps its carry-out so a count step off all-ones is visible.
  logic [WIDTH:0] w_sum;
  logic           w_carry;
  logic           r_wrap;

  assign w_sum   = {1'b0, w_pc} + (WIDTH + 1)'(1);
  assign w_inc   = w_sum[WIDTH-1:0];
  assign w_carry = w_sum[WIDTH];

  // Only a COUNT step can raise the flag, so a jump to zero never does;
  // reset and clear fall out as non-COUNT modes but are also explicit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= (w_mode == PC_COUNT) && w_carry;
    end
  end

  assign wrap = r_wrap;
`else
  // Carry-out discarded: wrap-around is silent.
  assign w_inc = w_pc + WIDTH'(1);
`endif

  always_comb begin
    w_next = w_pc;
    case (w_mode)
      PC_RESET: w_next = RESET_VAL;
      PC_CLEAR: w_next = RESET_VAL;
      PC_JUMP:  w_next = in;
      PC_COUNT: w_next = w_inc;
      default:  w_next = w_pc;
    endcase
  end

  // Holding is done by the register's load gate rather than by feeding
  // the current value back through the mux.
  assign w_reg_load = (w_mode != PC_HOLD);

  pc_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_pc_register (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_reg_load),
    .i_d    (w_next),
    .o_q    (w_pc)
  );

  assign out = w_pc;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
// Directed bench for program_counter. A behavioural model tracks the PC as
// an integer following the priority rules; a compare process checks out
// (and wrap when PROGRAM_COUNTER_WRAP_FLAG_EN is defined) against it every
// cycle, and each directed step also checks a hand-computed literal.
// ---------------------------------------------------------------------------
module tb_program_counter;
  import program_counter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        load;
  logic        inc;
  logic [15:0] in;
  logic [15:0] out;
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
  logic        wrap;
`endif

  int total = 0;
  int bad   = 0;

  program_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .in    (in),
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    .out   (out),
    .wrap  (wrap)
`else
    .out   (out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int       model_pc    = 0;
  bit       model_wrap  = 1'b0;
  bit       model_valid = 1'b0;
  int       cov [5];
  pc_mode_e mode_now;

  always @(posedge clk) begin
    if (!rst_n) begin
      mode_now = PC_RESET;
    end else if (clr) begin
      mode_now = PC_CLEAR;
    end else if (load) begin
      mode_now = PC_JUMP;
    end else if (inc) begin
      mode_now = PC_COUNT;
    end else begin
      mode_now = PC_HOLD;
    end
    cov[int'(mode_now)] = cov[int'(mode_now)] + 1;

    model_wrap = (mode_now == PC_COUNT) && (model_pc == 65535);
    case (mode_now)
      PC_RESET, PC_CLEAR: model_pc = 0;
      PC_JUMP:            model_pc = int'(in);
      PC_COUNT:           model_pc = (model_pc + 1) % 65536;
      default:            model_pc = model_pc;
    endcase
    if (mode_now == PC_RESET) model_valid = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      total = total + 1;
      if (int'(out) != model_pc) begin
        bad = bad + 1;
        $display("FAIL model_out t=%0t got=%h want=%h", $time, out, model_pc[15:0]);
      end
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
      total = total + 1;
      if (wrap !== model_wrap) begin
        bad = bad + 1;
        $display("FAIL model_wrap t=%0t got=%b want=%b", $time, wrap, model_wrap);
      end
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  // Drive one cycle of controls, check out did not move before the edge,
  // then check the hand-computed result after the edge.
  task automatic step(input logic r, input logic c, input logic l, input logic i,
                      input logic [15:0] d, input logic [15:0] exp_out,
                      input logic exp_wrap, input string name);
    rst_n = r; clr = c; load = l; inc = i; in = d;
    #1;
    if (model_valid) begin
      total = total + 1;
      if (int'(out) != model_pc) begin
        bad = bad + 1;
        $display("FAIL %s_nocomb got=%h want=%h", name, out, model_pc[15:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total = total + 1;
    if (out !== exp_out) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h", name, out, exp_out);
    end
`ifdef PROGRAM_COUNTER_WRAP_FLAG_EN
    total = total + 1;
    if (wrap !== exp_wrap) begin
      bad = bad + 1;
      $display("FAIL %s_wrap got=%b want=%b", name, wrap, exp_wrap);
    end
`endif
    $display("step %-10s rst_n=%b clr=%b load=%b inc=%b in=%h -> out=%h", name, r, c, l, i, d, out);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; inc = 1'b0; in = 16'h0000;
    @(negedge clk);

    // reset and count
    step(0, 0, 0, 0, 16'h0000, 16'h0000, 0, "reset0");
    step(0, 0, 0, 0, 16'h0000, 16'h0000, 0, "reset1");
    step(1, 0, 0, 1, 16'h0000, 16'h0001, 0, "count1");
    step(1, 0, 0, 1, 16'h0000, 16'h0002, 0, "count2");
    step(1, 0, 0, 1, 16'h0000, 16'h0003, 0, "count3");
    step(1, 0, 0, 1, 16'h0000, 16'h0004, 0, "count4");
    step(1, 0, 0, 1, 16'h0000, 16'h0005, 0, "count5");

    // jump then count
    step(1, 0, 1, 0, 16'h1234, 16'h1234, 0, "jump");
    step(1, 0, 0, 1, 16'h0000, 16'h1235, 0, "jinc1");
    step(1, 0, 0, 1, 16'h0000, 16'h1236, 0, "jinc2");

    // priority
    step(1, 0, 1, 1, 16'h00A0, 16'h00A0, 0, "load_inc");
    step(1, 1, 1, 0, 16'h0055, 16'h0000, 0, "clr_load");
    step(1, 0, 0, 1, 16'hBEEF, 16'h0001, 0, "in_ignored");
    step(1, 1, 0, 1, 16'h0000, 16'h0000, 0, "clr_inc");

    // wrap
    step(1, 0, 1, 0, 16'hFFFE, 16'hFFFE, 0, "load_fffe");
    step(1, 0, 0, 1, 16'h0000, 16'hFFFF, 0, "wrap_pre");
    step(1, 0, 0, 1, 16'h0000, 16'h0000, 1, "wrap");
    step(1, 0, 0, 0, 16'h0000, 16'h0000, 0, "wrap_hold");
    step(1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, "load_ffff");
    step(1, 0, 1, 0, 16'h0000, 16'h0000, 0, "load_zero");
    step(1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, "load_ffff2");
    step(1, 1, 0, 1, 16'h0000, 16'h0000, 0, "clr_at_max");

    // hold and mid-run reset
    step(1, 0, 1, 0, 16'h0010, 16'h0010, 0, "load_10");
    step(1, 0, 0, 0, 16'h0000, 16'h0010, 0, "hold1");
    step(1, 0, 0, 0, 16'h0000, 16'h0010, 0, "hold2");
    step(1, 0, 0, 0, 16'h0000, 16'h0010, 0, "hold3");
    step(0, 0, 1, 1, 16'h0777, 16'h0000, 0, "midreset");
    step(1, 0, 0, 1, 16'h0000, 16'h0001, 0, "resume");
    step(1, 0, 0, 1, 16'h0000, 16'h0002, 0, "resume2");

    $display("coverage reset=%0d clear=%0d jump=%0d count=%0d hold=%0d",
             cov[0], cov[1], cov[2], cov[3], cov[4]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_program_counter
